// File: rtl/valid_delay_pkg.sv
// Shared constants and the tap-select clamp for the valid delay line.
package valid_delay_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int MAX_DEPTH     = 32;

    function automatic int clamp_sel(input int sel, input int depth);
        return (sel > depth) ? depth : sel;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {data, valid} register of the delay line; flush outranks enable.
module delay_stage
    import valid_delay_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/valid_delay_line.sv
// Multi-tap data/valid delay line with selectable output tap, stall, flush,
// fill tracking and registered edge pulses on the selected valid.
module valid_delay_line
    import valid_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   datavalid,
    input  logic [SELW-1:0]        sel,
    output logic [DEPTH*WIDTH-1:0] tap_data,
    output logic [DEPTH-1:0]       tap_valid,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic                   primed,
    output logic                   rise_pulse,
    output logic                   fall_pulse
);

    localparam int CNTW = $clog2(DEPTH + 1);

    // taps[0] is the live input, taps[k] the output of stage k, so the
    // clamped select indexes the array directly.
    logic [WIDTH:0]  taps [DEPTH+1];
    logic [SELW-1:0] sel_c;
    logic [CNTW-1:0] fill_cnt;
    logic            valid_prev;

    assign taps[0] = {data_in, datavalid};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        delay_stage #(
            .W (WIDTH + 1)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .flush (flush),
            .d     (taps[k-1]),
            .q     (taps[k])
        );

        assign tap_data[k*WIDTH-1 -: WIDTH] = taps[k][WIDTH:1];
        assign tap_valid[k-1]               = taps[k][0];
    end

    assign sel_c = SELW'(clamp_sel(int'(sel), DEPTH));

    always_comb begin
        data_out  = taps[sel_c][WIDTH:1];
        valid_out = taps[sel_c][0];
    end

    // Fill count saturates at DEPTH so primed stays valid indefinitely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt <= '0;
        end else if (flush) begin
            fill_cnt <= '0;
        end else if (en && (int'(fill_cnt) < DEPTH)) begin
            fill_cnt <= fill_cnt + CNTW'(1);
        end
    end

    assign primed = (int'(fill_cnt) >= int'(sel_c));

    // Edge history runs every clock, so a stall or a select change that
    // moves valid_out is still reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_prev <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            valid_prev <= valid_out;
            rise_pulse <= valid_out & ~valid_prev;
            fall_pulse <= ~valid_out & valid_prev;
        end
    end

endmodule
